hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use stall / branch flush controller for the IF/ID/EX front end.
// Optional stall performance counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES   = 1,
  parameter int unsigned BRANCH_FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] idInstr,
  input  logic        exMemRead,
  input  logic [4:0]  exDestReg,
  input  logic        branchTaken,
  input  logic        extStall,
  output logic        pcWriteEnable,
  output logic        ifIdWriteEnable,
  output logic        ifIdFlush,
  output logic        idExBubble,
  output logic [1:0]  ctrlState,
  output logic [15:0] stallCount
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;
  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(BRANCH_FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic             w_hazard;
  logic             w_unused;

  assign w_rs     = idInstr[25:21];
  assign w_rt     = idInstr[20:16];
  assign w_unused = ^{idInstr[31:26], idInstr[15:0]};

  // Load in EX writes a register the instruction in ID reads; r0 never hazards
  assign w_hazard = exMemRead && (exDestReg != 5'd0) &&
                    ((exDestReg == w_rs) || (exDestReg == w_rt));

  // Mealy outputs and next state, priority Reset > extStall > branchTaken > hazard
  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    pcWriteEnable   = 1'b1;
    ifIdWriteEnable = 1'b1;
    ifIdFlush       = 1'b0;
    idExBubble      = 1'b0;
    if (Reset) begin
      pcWriteEnable   = 1'b0;
      ifIdWriteEnable = 1'b0;
      idExBubble      = 1'b1;
    end else if (extStall) begin
      pcWriteEnable   = 1'b0;
      ifIdWriteEnable = 1'b0;
    end else if (branchTaken) begin
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        w_next_state = FLUSH;
        w_next_cnt   = FLUSH_RELOAD;
      end else begin
        w_next_state = RUN;
        w_next_cnt   = '0;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard) begin
            pcWriteEnable   = 1'b0;
            ifIdWriteEnable = 1'b0;
            idExBubble      = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              w_next_state = STALL;
              w_next_cnt   = LOAD_RELOAD;
            end
          end
        end
        STALL: begin
          pcWriteEnable   = 1'b0;
          ifIdWriteEnable = 1'b0;
          idExBubble      = 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            w_next_state = RUN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        FLUSH: begin
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            w_next_state = RUN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  assign ctrlState = Reset ? 2'd0 : 2'(r_state);

`ifdef HAZARD_STALL_COUNT_EN
  logic [STAT_W-1:0] r_stall_count;

  // Counts front-end stall cycles caused by hazards, saturating
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_count <= '0;
    end else if (!pcWriteEnable && !extStall && (r_stall_count != {STAT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + STAT_W'(1);
    end
  end

  assign stallCount = r_stall_count;
`else
  assign stallCount = STAT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table on a default-parameter instance,
// plus hand sequences on multi-cycle stall/flush instances.
module tb_hazard_ctrl;

`ifdef HAZARD_STALL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic [31:0] idInstr;
  logic        exMemRead;
  logic [4:0]  exDestReg;
  logic        branchTaken;
  logic        extStall;

  logic a_pcwe, a_ifid, a_flush, a_bub;
  logic b_pcwe, b_ifid, b_flush, b_bub;
  logic c_pcwe, c_ifid, c_flush, c_bub;
  logic [1:0]  a_state, b_state, c_state;
  logic [15:0] a_cnt, b_cnt, c_cnt;
  logic [5:0]  a_obs, b_obs, c_obs;

  assign a_obs = {a_pcwe, a_ifid, a_flush, a_bub, a_state};
  assign b_obs = {b_pcwe, b_ifid, b_flush, b_bub, b_state};
  assign c_obs = {c_pcwe, c_ifid, c_flush, c_bub, c_state};

  hazard_ctrl u_a (
    .Clk(Clk), .Reset(Reset), .idInstr(idInstr), .exMemRead(exMemRead),
    .exDestReg(exDestReg), .branchTaken(branchTaken), .extStall(extStall),
    .pcWriteEnable(a_pcwe), .ifIdWriteEnable(a_ifid), .ifIdFlush(a_flush),
    .idExBubble(a_bub), .ctrlState(a_state), .stallCount(a_cnt)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(1)) u_b (
    .Clk(Clk), .Reset(Reset), .idInstr(idInstr), .exMemRead(exMemRead),
    .exDestReg(exDestReg), .branchTaken(branchTaken), .extStall(extStall),
    .pcWriteEnable(b_pcwe), .ifIdWriteEnable(b_ifid), .ifIdFlush(b_flush),
    .idExBubble(b_bub), .ctrlState(b_state), .stallCount(b_cnt)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(4)) u_c (
    .Clk(Clk), .Reset(Reset), .idInstr(idInstr), .exMemRead(exMemRead),
    .exDestReg(exDestReg), .branchTaken(branchTaken), .extStall(extStall),
    .pcWriteEnable(c_pcwe), .ifIdWriteEnable(c_ifid), .ifIdFlush(c_flush),
    .idExBubble(c_bub), .ctrlState(c_state), .stallCount(c_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected {pcWriteEnable, ifIdWriteEnable, ifIdFlush, idExBubble}
  localparam logic [3:0] E_RUN = 4'b1100;
  localparam logic [3:0] E_STL = 4'b0001;
  localparam logic [3:0] E_FLS = 4'b1111;
  localparam logic [3:0] E_FRZ = 4'b0000;
  localparam logic [3:0] E_RST = 4'b0001;

  typedef struct {
    logic       rst;
    logic       mr;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       ext;
    logic [3:0] exp_ctl;
  } vec_t;

  vec_t vecs[15];
  int   n_cmp;
  int   n_fail;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [5:0] act,
                     input logic [3:0] ctl, input logic [1:0] st);
    check(name, 16'(act), 16'({ctl, st}));
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] act, input int n);
    check(name, act, CNT_EN ? 16'(n) : 16'd0);
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 2ns later
  task automatic apply(input logic rst, input logic mr, input logic [4:0] dest,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic ext);
    @(posedge Clk);
    #1;
    Reset       = rst;
    exMemRead   = mr;
    exDestReg   = dest;
    idInstr     = {6'b010001, rs, rt, 16'h0000};
    branchTaken = br;
    extStall    = ext;
    #2;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic hazard_rt2();
    apply(1'b0, 1'b1, 5'd2, 5'd5, 5'd2, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_cnt;
    n_cmp       = 0;
    n_fail      = 0;
    exp_cnt     = 0;
    Reset       = 1'b1;
    exMemRead   = 1'b0;
    exDestReg   = 5'd0;
    idInstr     = 32'h0;
    branchTaken = 1'b0;
    extStall    = 1'b0;

    //            rst   mr    dest  rs    rt    br    ext   expected
    vecs[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RST};
    vecs[1]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RUN};
    vecs[2]  = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0, E_STL};
    vecs[3]  = '{1'b0, 1'b0, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0, E_RUN};
    vecs[4]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RST};
    vecs[5]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RUN};
    vecs[6]  = '{1'b0, 1'b1, 5'd2, 5'd5, 5'd2, 1'b0, 1'b0, E_STL};
    vecs[7]  = '{1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, E_RUN};
    vecs[8]  = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, E_FRZ};
    vecs[9]  = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, E_FLS};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, E_FRZ};
    vecs[11] = '{1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, E_STL};
    vecs[12] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, E_RST};
    vecs[13] = '{1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, E_STL};
    vecs[14] = '{1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, E_STL};

    // Default parameters: single-cycle stall/flush, state never leaves RUN
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].rst, vecs[i].mr, vecs[i].dest, vecs[i].rs, vecs[i].rt,
            vecs[i].br, vecs[i].ext);
      chk($sformatf("vec%0d_ctl", i), a_obs, vecs[i].exp_ctl, 2'd0);
      if (i > 0) chk_cnt($sformatf("vec%0d_cnt", i), a_cnt, exp_cnt);
      if (vecs[i].rst) exp_cnt = 0;
      else if (!vecs[i].exp_ctl[3] && !vecs[i].ext) exp_cnt++;
    end
    idle();
    chk_cnt("vec_final_cnt", a_cnt, exp_cnt);

    // Three-cycle stall on rt match, then a hazard arriving as STALL ends
    do_reset();
    chk("b_reset", b_obs, E_RST, 2'd0);
    hazard_rt2(); chk("b_stall1", b_obs, E_STL, 2'd0);
    idle();       chk("b_stall2", b_obs, E_STL, 2'd1);
    idle();       chk("b_stall3", b_obs, E_STL, 2'd1);
    idle();       chk("b_run",    b_obs, E_RUN, 2'd0);
    chk_cnt("b_cnt3", b_cnt, 3);
    hazard_rt2(); chk("b_h_a1", b_obs, E_STL, 2'd0);
    idle();       chk("b_h_a2", b_obs, E_STL, 2'd1);
    hazard_rt2(); chk("b_h_a3", b_obs, E_STL, 2'd1);
    hazard_rt2(); chk("b_h_b1", b_obs, E_STL, 2'd0);
    idle();       chk("b_h_b2", b_obs, E_STL, 2'd1);
    idle();       chk("b_h_b3", b_obs, E_STL, 2'd1);
    idle();       chk("b_h_run", b_obs, E_RUN, 2'd0);
    chk_cnt("b_cnt9", b_cnt, 9);

    // Branch in the second stall cycle aborts the stall
    do_reset();
    hazard_rt2(); chk("b_br_stall", b_obs, E_STL, 2'd0);
    apply(1'b0, 1'b1, 5'd2, 5'd5, 5'd2, 1'b1, 1'b0);
    chk("b_br_flush", b_obs, E_FLS, 2'd1);
    idle();       chk("b_br_run", b_obs, E_RUN, 2'd0);
    chk_cnt("b_br_cnt", b_cnt, 1);

    // extStall freezes a stall in progress for four cycles
    do_reset();
    hazard_rt2(); chk("b_ext_s1", b_obs, E_STL, 2'd0);
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b1, 5'd2, 5'd5, 5'd2, 1'b0, 1'b1);
      chk($sformatf("b_ext_frz%0d", k), b_obs, E_FRZ, 2'd1);
    end
    idle();       chk("b_ext_s2", b_obs, E_STL, 2'd1);
    idle();       chk("b_ext_s3", b_obs, E_STL, 2'd1);
    idle();       chk("b_ext_run", b_obs, E_RUN, 2'd0);
    chk_cnt("b_ext_cnt", b_cnt, 3);

    // Four-cycle flush ignoring hazards, with a reload from a second branch
    do_reset();
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("c_fl_br", c_obs, E_FLS, 2'd0);
    apply(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    chk("c_fl_haz", c_obs, E_FLS, 2'd2);
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("c_fl_reload", c_obs, E_FLS, 2'd2);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
      chk($sformatf("c_fl_tail%0d", k), c_obs, E_FLS, 2'd2);
    end
    idle();       chk("c_fl_run", c_obs, E_RUN, 2'd0);
    chk_cnt("c_fl_cnt", c_cnt, 0);

    // Stall aborted into FLUSH, then reset mid-flush
    do_reset();
    hazard_rt2(); chk("c_rs_stall", c_obs, E_STL, 2'd0);
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("c_rs_br", c_obs, E_FLS, 2'd1);
    idle();       chk("c_rs_flush", c_obs, E_FLS, 2'd2);
    chk_cnt("c_rs_cnt1", c_cnt, 1);
    do_reset();   chk("c_rs_reset", c_obs, E_RST, 2'd0);
    idle();       chk("c_rs_run", c_obs, E_RUN, 2'd0);
    check("c_rs_cnt0", c_cnt, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
